load_nanofs: RTL and testbench

Boot-image loader placed directly downstream of the NanoFS directory search. When the search reports success, its start-block output is fed here as `start_block`. This block walks the file's chain of data blocks on the SD card through the shared SPI block-reader port. It packs the payload bytes into 32-bit little-endian words and writes them sequentially into the boot RAM. It asserts `done` once the last block is consumed, or `err` on any fault.

---
 rtl/load_nanofs.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_load_nanofs.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_nanofs.sv
// load_nanofs: walks a NanoFS data-block chain through the shared SPI block
// reader and packs the payload bytes, little-endian, into 32-bit words that are
// written sequentially into the boot RAM.
module load_nanofs #(
  parameter int unsigned MEM_ADDR_WIDTH = 14,
  parameter int unsigned MAX_BLOCKS     = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [31:0]               start_block,
  input  logic [31:0]               offset,
  output logic                      done,
  output logic                      err,
  output logic [31:0]               bytes_loaded,
  output logic                      spi_r_block,
  output logic                      spi_r_byte,
  input  logic                      spi_busy,
  input  logic                      spi_err,
  output logic [31:0]               spi_block_addr,
  input  logic [7:0]                spi_data_out,
  output logic                      mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]               mem_din
);

  localparam int unsigned BLK_W = $clog2(MAX_BLOCKS + 1);
  localparam logic [15:0] MAX_LEN = 16'd506;
  localparam logic [MEM_ADDR_WIDTH-1:0] ADDR_MAX = '1;
  localparam logic [BLK_W-1:0] BLK_LIMIT = BLK_W'(MAX_BLOCKS);

  typedef enum logic [4:0] {
    S_IDLE,
    S_SETUP,
    S_CHANGE_BLOCK,
    S_WAIT_CHANGE_BLOCK,
    S_READ_BLOCK,
    S_WAIT_BLOCK,
    S_READ_HDR,
    S_HDR_BYTE,
    S_WAIT_HDR_BYTE,
    S_CHECK_HDR,
    S_READ_DATA,
    S_DATA_BYTE,
    S_WAIT_DATA_BYTE,
    S_NEXT_BLOCK,
    S_FLUSH,
    S_DONE,
    S_ERROR
  } state_t;

  state_t            state;
  logic [2:0]        hdr_cnt;    // header byte index within the open block
  logic [8:0]        pay_cnt;    // payload bytes consumed from the open block
  logic [31:0]       next_blk;   // chain link from the header
  logic [15:0]       len;        // payload length from the header
  logic [BLK_W-1:0]  blk_cnt;    // blocks finished so far (loop protection)
  logic [31:0]       word_buf;   // partially packed word, unused lanes zero
  logic              mem_full;   // last RAM word has been written

  logic [1:0]        lane_c;
  logic [31:0]       word_c;
  logic [8:0]        pay_nxt_c;
  logic [BLK_W-1:0]  blk_nxt_c;
  logic              active_c;

  // Byte-lane packing and counter look-ahead for the sequencer.
  always_comb begin
    lane_c    = bytes_loaded[1:0];
    word_c    = word_buf | (32'(spi_data_out) << {lane_c, 3'b000});
    pay_nxt_c = pay_cnt + 9'd1;
    blk_nxt_c = blk_cnt + BLK_W'(1);
    active_c  = (state != S_IDLE) && (state != S_DONE) && (state != S_ERROR);
  end

  // Load sequencer: block chain walk, header decode, word packing and RAM writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      done           <= 1'b0;
      err            <= 1'b0;
      bytes_loaded   <= '0;
      spi_r_block    <= 1'b0;
      spi_r_byte     <= 1'b0;
      spi_block_addr <= '0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_din        <= '0;
      hdr_cnt        <= '0;
      pay_cnt        <= '0;
      next_blk       <= '0;
      len            <= '0;
      blk_cnt        <= '0;
      word_buf       <= '0;
      mem_full       <= 1'b0;
    end else begin
      spi_r_byte <= 1'b0;
      mem_we     <= 1'b0;

      // Address advances the cycle after each write and saturates at the top.
      if (mem_we) begin
        if (mem_addr == ADDR_MAX) begin
          mem_full <= 1'b1;
        end else begin
          mem_addr <= mem_addr + MEM_ADDR_WIDTH'(1);
        end
      end

      if (active_c && spi_err) begin
        // A reader fault overrides whatever the current state would do.
        state       <= S_ERROR;
        err         <= 1'b1;
        spi_r_block <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            done           <= 1'b0;
            err            <= 1'b0;
            bytes_loaded   <= '0;
            spi_r_block    <= 1'b0;
            spi_block_addr <= '0;
            mem_addr       <= '0;
            mem_din        <= '0;
            hdr_cnt        <= '0;
            pay_cnt        <= '0;
            next_blk       <= '0;
            len            <= '0;
            blk_cnt        <= '0;
            word_buf       <= '0;
            mem_full       <= 1'b0;
            if (start) begin
              state <= S_SETUP;
            end
          end

          S_SETUP: begin
            spi_block_addr <= start_block + offset;
            state          <= S_CHANGE_BLOCK;
          end

          S_CHANGE_BLOCK: begin
            hdr_cnt <= '0;
            state   <= S_WAIT_CHANGE_BLOCK;
          end

          S_WAIT_CHANGE_BLOCK: begin
            if (!spi_busy) begin
              spi_r_block <= 1'b1;
              state       <= S_READ_BLOCK;
            end
          end

          S_READ_BLOCK: begin
            state <= S_WAIT_BLOCK;
          end

          S_WAIT_BLOCK: begin
            if (!spi_busy) begin
              state <= S_READ_HDR;
            end
          end

          S_READ_HDR: begin
            case (hdr_cnt)
              3'd0:    next_blk[7:0]   <= spi_data_out;
              3'd1:    next_blk[15:8]  <= spi_data_out;
              3'd2:    next_blk[23:16] <= spi_data_out;
              3'd3:    next_blk[31:24] <= spi_data_out;
              3'd4:    len[7:0]        <= spi_data_out;
              3'd5:    len[15:8]       <= spi_data_out;
              default: ;
            endcase
            // At index 6 the reader already presents the first payload byte.
            if (hdr_cnt < 3'd6) begin
              state <= S_HDR_BYTE;
            end else begin
              state <= S_CHECK_HDR;
            end
          end

          S_HDR_BYTE: begin
            spi_r_byte <= 1'b1;
            hdr_cnt    <= hdr_cnt + 3'd1;
            state      <= S_WAIT_HDR_BYTE;
          end

          S_WAIT_HDR_BYTE: begin
            if (!spi_busy) begin
              state <= S_READ_HDR;
            end
          end

          S_CHECK_HDR: begin
            if (len > MAX_LEN) begin
              state       <= S_ERROR;
              err         <= 1'b1;
              spi_r_block <= 1'b0;
            end else if (len == 16'd0) begin
              state <= S_NEXT_BLOCK;
            end else begin
              pay_cnt <= '0;
              state   <= S_READ_DATA;
            end
          end

          S_READ_DATA: begin
            if ((lane_c == 2'd3) && mem_full) begin
              // Word would land past the end of the boot RAM.
              state       <= S_ERROR;
              err         <= 1'b1;
              spi_r_block <= 1'b0;
            end else begin
              bytes_loaded <= bytes_loaded + 32'd1;
              pay_cnt      <= pay_nxt_c;
              if (lane_c == 2'd3) begin
                mem_we   <= 1'b1;
                mem_din  <= word_c;
                word_buf <= '0;
              end else begin
                word_buf <= word_c;
              end
              if ({7'd0, pay_nxt_c} == len) begin
                state <= S_NEXT_BLOCK;
              end else begin
                state <= S_DATA_BYTE;
              end
            end
          end

          S_DATA_BYTE: begin
            spi_r_byte <= 1'b1;
            state      <= S_WAIT_DATA_BYTE;
          end

          S_WAIT_DATA_BYTE: begin
            if (!spi_busy) begin
              state <= S_READ_DATA;
            end
          end

          S_NEXT_BLOCK: begin
            spi_r_block <= 1'b0;
            blk_cnt     <= blk_nxt_c;
            if (next_blk == 32'd0) begin
              state <= S_FLUSH;
            end else if (blk_nxt_c == BLK_LIMIT) begin
              state <= S_ERROR;
              err   <= 1'b1;
            end else begin
              spi_block_addr <= next_blk + offset;
              state          <= S_CHANGE_BLOCK;
            end
          end

          S_FLUSH: begin
            if (lane_c != 2'd0) begin
              if (mem_full) begin
                state <= S_ERROR;
                err   <= 1'b1;
              end else begin
                mem_we   <= 1'b1;
                mem_din  <= word_buf;
                word_buf <= '0;
                state    <= S_DONE;
                done     <= 1'b1;
              end
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end

          S_DONE: begin
            done <= 1'b1;
          end

          S_ERROR: begin
            err         <= 1'b1;
            spi_r_block <= 1'b0;
          end

          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_load_nanofs.sv
// Bench for load_nanofs: a small SD-card disk image served through a reactive
// SPI block-reader model, checked against a chain-walking reference model.
module tb_load_nanofs;

  localparam int unsigned AW    = 8;
  localparam int unsigned MAXB  = 4;
  localparam int unsigned NSLOT = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [31:0]   start_block;
  logic [31:0]   offset;
  logic          done;
  logic          err;
  logic [31:0]   bytes_loaded;
  logic          spi_r_block;
  logic          spi_r_byte;
  logic          spi_busy;
  logic          spi_err;
  logic [31:0]   spi_block_addr;
  logic [7:0]    spi_data_out;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_din;

  load_nanofs #(.MEM_ADDR_WIDTH(AW), .MAX_BLOCKS(MAXB)) dut (
    .clk(clk), .reset(reset), .start(start), .start_block(start_block),
    .offset(offset), .done(done), .err(err), .bytes_loaded(bytes_loaded),
    .spi_r_block(spi_r_block), .spi_r_byte(spi_r_byte), .spi_busy(spi_busy),
    .spi_err(spi_err), .spi_block_addr(spi_block_addr),
    .spi_data_out(spi_data_out), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0]  disk [NSLOT][512];
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [31:0] blk_q[$];
  logic [31:0] exp_words[$];
  logic [31:0] exp_blocks[$];
  bit          exp_done;
  bit          exp_err;
  int          exp_bytes;
  int          inj_at = -1;
  bit          injected = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
    end
  endtask

  // Block reader, RAM monitor and fault injector, all acting on the falling edge.
  initial begin : reader
    bit          rd_open;
    bit          err_chk;
    int unsigned rd_slot;
    int unsigned rd_idx;
    int unsigned rd_wait;
    rd_open = 0; err_chk = 0; rd_slot = 0; rd_idx = 0; rd_wait = 0;
    spi_busy = 1'b0; spi_err = 1'b0; spi_data_out = 8'h00;
    forever begin
      @(negedge clk);
      if (mem_we) begin
        wr_addr_q.push_back(32'(mem_addr));
        wr_data_q.push_back(mem_din);
      end
      if (!spi_r_block) begin
        rd_open = 0;
        rd_wait = 0;
      end else if (!rd_open) begin
        rd_open = 1;
        blk_q.push_back(spi_block_addr);
        rd_slot = (spi_block_addr - offset) % NSLOT;
        rd_idx  = 0;
        rd_wait = $urandom_range(0, 3);
      end else if (spi_r_byte) begin
        rd_idx++;
        rd_wait = $urandom_range(0, 2);
      end else if (rd_wait != 0) begin
        rd_wait--;
      end
      spi_busy     = (rd_wait != 0);
      spi_data_out = rd_open ? disk[rd_slot][rd_idx % 512] : 8'h00;
      if (err_chk) begin
        check("err_next_cycle", 32'(err), 32'd1);
        err_chk = 0;
      end
      spi_err = 1'b0;
      if (inj_at > 0 && !injected && bytes_loaded == 32'(inj_at)) begin
        spi_err  = 1'b1;
        injected = 1'b1;
        err_chk  = 1;
      end
    end
  end

  // Payload byte i is base + i*step, or random.
  task automatic put_block(input int unsigned slot, input logic [31:0] nxt, input logic [15:0] len,
                           input logic [7:0] base, input logic [7:0] step, input bit rnd);
    logic [7:0] b;
    b = base;
    for (int i = 0; i < 4; i++) disk[slot][i] = nxt[8*i +: 8];
    disk[slot][4] = len[7:0];
    disk[slot][5] = len[15:8];
    for (int i = 0; i < int'(len) && i < 506; i++) begin
      disk[slot][6+i] = rnd ? 8'($urandom) : b;
      b = b + step;
    end
  endtask

  // Reference: follow the chain, gather the payload stream, cut it into words.
  task automatic model(input int unsigned first, input logic [31:0] off);
    logic [7:0]  pl[$];
    int unsigned slot;
    logic [31:0] nxt;
    logic [15:0] len;
    bit          bad;
    int          nw;
    slot = first; bad = 0;
    exp_words.delete();
    exp_blocks.delete();
    for (int b = 0; b < int'(MAXB); b++) begin
      exp_blocks.push_back(32'(slot) + off);
      nxt = {disk[slot][3], disk[slot][2], disk[slot][1], disk[slot][0]};
      len = {disk[slot][5], disk[slot][4]};
      if (len > 16'd506) begin
        bad = 1;
        break;
      end
      for (int i = 0; i < int'(len); i++) pl.push_back(disk[slot][6+i]);
      if (nxt == 32'd0) break;
      if (b == int'(MAXB) - 1) bad = 1;
      slot = nxt % NSLOT;
    end
    nw = bad ? pl.size() / 4 : (pl.size() + 3) / 4;
    if (nw > (1 << AW)) begin
      bad = 1;
      nw  = 1 << AW;
    end
    for (int w = 0; w < nw; w++) begin
      logic [31:0] word;
      word = 32'd0;
      for (int j = 0; j < 4; j++)
        if (4*w + j < pl.size()) word[8*j +: 8] = pl[4*w + j];
      exp_words.push_back(word);
    end
    exp_err   = bad;
    exp_done  = !bad;
    exp_bytes = pl.size();
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    wr_addr_q.delete();
    wr_data_q.delete();
    blk_q.delete();
  endtask

  // k: -1 no fault, 0 fault at a random payload byte, >0 fault at that byte.
  task automatic run_load(input int unsigned first, input logic [31:0] off, input int k);
    int cyc;
    pulse_reset();
    offset      = off;
    start_block = 32'(first);
    model(first, off);
    if (k == 0) k = (!exp_err && exp_bytes >= 2) ? int'($urandom_range(1, exp_bytes - 1)) : -1;
    if (k > 0) begin
      exp_err  = 1;
      exp_done = 0;
      while (exp_words.size() > k / 4) void'(exp_words.pop_back());
    end
    injected = 1'b0;
    inj_at   = k;
    start    = 1'b1;
    cyc      = 0;
    while (!(done || err) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    check("finished", 32'(done | err), 32'd1);
    repeat (4) @(negedge clk);
    start  = 1'b0;
    inj_at = -1;
    check("done", 32'(done), 32'(exp_done));
    check("err", 32'(err), 32'(exp_err));
    check("n_writes", 32'(wr_data_q.size()), 32'(exp_words.size()));
    for (int i = 0; i < exp_words.size() && i < wr_data_q.size(); i++) begin
      check($sformatf("wr_addr[%0d]", i), wr_addr_q[i], 32'(i));
      check($sformatf("wr_data[%0d]", i), wr_data_q[i], exp_words[i]);
    end
    if (k < 0) begin
      check("n_blocks", 32'(blk_q.size()), 32'(exp_blocks.size()));
      for (int i = 0; i < exp_blocks.size() && i < blk_q.size(); i++)
        check($sformatf("blk_addr[%0d]", i), blk_q[i], exp_blocks[i]);
    end
    if (!exp_err) check("bytes_loaded", bytes_loaded, 32'(exp_bytes));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_bytes"}, bytes_loaded, 32'd0);
    check({tag, "_r_block"}, 32'(spi_r_block), 32'd0);
    check({tag, "_r_byte"}, 32'(spi_r_byte), 32'd0);
    check({tag, "_blk_addr"}, spi_block_addr, 32'd0);
    check({tag, "_we"}, 32'(mem_we), 32'd0);
    check({tag, "_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_din"}, mem_din, 32'd0);
  endtask

  initial begin : main
    int cyc;
    reset = 1'b1; start = 1'b0; start_block = 32'd0; offset = 32'd0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;

    // Single block, len 8, offset 0x100.
    put_block(3, 32'd0, 16'd8, 8'h01, 8'h01, 0);
    run_load(3, 32'h100, -1);
    if (blk_q.size() >= 1) check("t1_blk", blk_q[0], 32'h103);
    if (wr_data_q.size() >= 2) begin
      check("t1_w0", wr_data_q[0], 32'h04030201);
      check("t1_w1", wr_data_q[1], 32'h08070605);
    end

    // Single block, len 5, partial word flushed.
    put_block(5, 32'd0, 16'd5, 8'hAA, 8'h11, 0);
    run_load(5, 32'd0, -1);
    if (wr_data_q.size() >= 2) check("t2_w1", wr_data_q[1], 32'h000000EE);

    // Two-block chain; packing continues across the boundary.
    put_block(2, 32'd7, 16'd3, 8'h11, 8'h11, 0);
    put_block(7, 32'd0, 16'd2, 8'h44, 8'h11, 0);
    run_load(2, 32'h40, -1);
    if (wr_data_q.size() >= 1) check("t3_w0", wr_data_q[0], 32'h44332211);

    // Illegal length.
    put_block(4, 32'd0, 16'd507, 8'h00, 8'h01, 1);
    run_load(4, 32'd0, -1);

    // Reader fault on the third payload byte.
    put_block(6, 32'd0, 16'd10, 8'h10, 8'h01, 0);
    run_load(6, 32'd0, 2);

    // Self-looping chain trips the block limit.
    put_block(8, 32'd8, 16'd4, 8'h00, 8'h01, 1);
    run_load(8, 32'd0, -1);

    // Chain of exactly the limit completes.
    put_block(9, 32'd10, 16'd3, 8'h00, 8'h01, 1);
    put_block(10, 32'd11, 16'd3, 8'h00, 8'h01, 1);
    put_block(11, 32'd12, 16'd3, 8'h00, 8'h01, 1);
    put_block(12, 32'd0, 16'd3, 8'h00, 8'h01, 1);
    run_load(9, 32'h1000, -1);

    // RAM filled exactly, then overfilled.
    put_block(13, 32'd14, 16'd506, 8'h00, 8'h01, 1);
    put_block(14, 32'd1, 16'd506, 8'h00, 8'h01, 1);
    put_block(1, 32'd0, 16'd12, 8'h00, 8'h01, 1);
    run_load(13, 32'd0, -1);
    put_block(1, 32'd15, 16'd12, 8'h00, 8'h01, 1);
    put_block(15, 32'd0, 16'd40, 8'h00, 8'h01, 1);
    run_load(13, 32'd0, -1);

    // Reset in the middle of the payload, then a fresh load.
    put_block(3, 32'd0, 16'd8, 8'h01, 8'h01, 0);
    pulse_reset();
    offset = 32'h100; start_block = 32'd3; start = 1'b1;
    cyc = 0;
    while (bytes_loaded != 32'd5 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check("mid_reach", bytes_loaded, 32'd5);
    reset = 1'b1;
    @(negedge clk);
    check_zero("mid_reset");
    reset = 1'b0;
    run_load(3, 32'h100, -1);

    // Random chains, every third with an injected reader fault.
    for (int t = 0; t < 12; t++) begin
      int unsigned nb, s0, step;
      int unsigned sl [3];
      nb   = $urandom_range(1, 3);
      s0   = $urandom_range(1, 15);
      step = $urandom_range(1, 4);
      for (int i = 0; i < 3; i++) sl[i] = ((s0 - 1 + i * step) % 15) + 1;
      for (int i = 0; i < int'(nb); i++)
        put_block(sl[i], (i < int'(nb) - 1) ? 32'(sl[i+1]) : 32'd0,
                  16'($urandom_range(0, 40)), 8'h00, 8'h00, 1);
      run_load(s0, $urandom, (t % 3 == 2) ? 0 : -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
